// File: rtl/invshiftrows_stream_pkg.sv
// Shared AES byte-stream constants and the column-major state index helper.
package invshiftrows_stream_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BYTE_W      = 8;

    typedef logic [3:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(AES_BLOCK_BYTES - 1);

    // Column-major state layout: byte k = row + 4*col.
    function automatic byte_idx_t col_major_idx(input logic [1:0] row, input logic [1:0] col);
        return {col, row};
    endfunction

endpackage

// File: rtl/invshiftrows_stream_if.sv
// Byte stream in/out handshake bundle for the (Inv)ShiftRows block.
interface invshiftrows_stream_if;
    import invshiftrows_stream_pkg::*;

    logic [AES_BYTE_W-1:0] in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic [AES_BYTE_W-1:0] out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output in_byte, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last
    );

    modport slave (
        input  in_byte, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last
    );

endinterface

// File: rtl/invshiftrows_stream_srows_src_idx.sv
// Maps an output byte index to the input byte index it is read from.
module srows_src_idx
    import invshiftrows_stream_pkg::*;
#(
    parameter bit INVERSE = 1'b1
) (
    input  byte_idx_t k,
    output byte_idx_t src
);

    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;

    assign row = k[1:0];
    assign col = k[3:2];

    // 2-bit wrap-around arithmetic gives the mod-4 column rotation for free.
    assign src_col = INVERSE ? (col - row) : (col + row);
    assign src     = col_major_idx(row, src_col);

endmodule

// File: rtl/invshiftrows_stream.sv
// Byte-serial AES (Inv)ShiftRows with two ping-pong 16-byte banks for 1 byte/cycle streaming.
module invshiftrows_stream
    import invshiftrows_stream_pkg::*;
#(
    parameter int DATA_W  = AES_BYTE_W,
    parameter bit INVERSE = 1'b1
) (
    input logic             clock,
    input logic             resetn,
    invshiftrows_stream_if.slave bus
);

    logic [DATA_W-1:0] bank0 [AES_BLOCK_BYTES];
    logic [DATA_W-1:0] bank1 [AES_BLOCK_BYTES];

    logic      wr_bank;
    logic      rd_bank;
    byte_idx_t wr_cnt;
    byte_idx_t rd_cnt;
    logic [1:0] full;

    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] full_set;
    logic [1:0] full_clr;
    byte_idx_t  rd_src;
    logic [DATA_W-1:0] rd_data;

    assign bus.in_ready  = ~full[wr_bank];
    assign bus.out_valid = full[rd_bank];

    assign wr_fire = bus.in_valid & bus.in_ready;
    assign rd_fire = bus.out_valid & bus.out_ready;

    srows_src_idx #(.INVERSE(INVERSE)) u_src_idx (
        .k   (rd_cnt),
        .src (rd_src)
    );

    assign rd_data      = rd_bank ? bank1[rd_src] : bank0[rd_src];
    assign bus.out_byte = bus.out_valid ? rd_data : '0;
    assign bus.out_last = bus.out_valid & (rd_cnt == LAST_IDX);

    // Filling and draining always target different banks, so set and clear never collide.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (wr_fire && (wr_cnt == LAST_IDX)) begin
            full_set = wr_bank ? 2'b10 : 2'b01;
        end
        if (rd_fire && (rd_cnt == LAST_IDX)) begin
            full_clr = rd_bank ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full    <= 2'b00;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 4'd1;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (rd_cnt == LAST_IDX) begin
                    rd_bank <= ~rd_bank;
                end
            end
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Bank storage carries no reset; full flags alone decide what is visible.
    always_ff @(posedge clock) begin
        if (wr_fire) begin
            if (wr_bank) begin
                bank1[wr_cnt] <= bus.in_byte;
            end else begin
                bank0[wr_cnt] <= bus.in_byte;
            end
        end
    end

endmodule
